// File: rtl/issue_queue_ctrl.sv
// Issue queue controller: circular buffer that accepts up to two entries
// from decode and presents the two oldest entries to the issue stage each
// cycle. Outputs depend only on registered state.
module issue_queue_ctrl #(
    parameter  int DEPTH  = 8,
    parameter  int ELEM_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flash,
    input  logic                   stall,
    input  logic [1:0]             push_number,
    input  logic [1:0][ELEM_W-1:0] push_data,
    output logic                   push_ready,
    output logic [1:0][ELEM_W-1:0] issue_require,
    output logic [1:0]             iq_size,
    input  logic [1:0]             iq_pop_number,
    output logic [CNT_W-1:0]       count
);

    logic [DEPTH-1:0][ELEM_W-1:0] mem;
    logic [PTR_W-1:0]             head, tail;
    logic [PTR_W-1:0]             head_p1, tail_p1;
    logic [1:0]                   push_eff, pop_eff;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Issue-side view and accept/consume amounts; all from registered state
    // except the effective push/pop, which only feed the next-state logic.
    always_comb begin
        iq_size          = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
        push_ready       = (count <= CNT_W'(DEPTH - 2));
        issue_require[0] = (count != '0)        ? mem[head]    : '0;
        issue_require[1] = (count >= CNT_W'(2)) ? mem[head_p1] : '0;
        // push_number==3 is treated as no push; a full-ish queue drops the offer
        push_eff = (push_ready && push_number != 2'd3) ? push_number : 2'd0;
        // pop never exceeds what is actually presented on issue_require
        if (stall)
            pop_eff = 2'd0;
        else if (iq_pop_number < iq_size)
            pop_eff = iq_pop_number;
        else
            pop_eff = iq_size;
    end

    // Entry storage: written at tail, never cleared (outputs are masked by count)
    always_ff @(posedge clk) begin
        if (!rst && !flash) begin
            if (push_eff != 2'd0)
                mem[tail] <= push_data[0];
            if (push_eff == 2'd2)
                mem[tail_p1] <= push_data[1];
        end
    end

    // Pointer and occupancy update; flush discards everything, including
    // any push or pop offered in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_eff);
            tail  <= tail + PTR_W'(push_eff);
            count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Self-checking bench for issue_queue_ctrl: a table of vectors with
// expected occupancy, plus a queue-based reference model whose entries
// are popped and compared whenever the DUT consumes from its head.
module tb_issue_queue_ctrl;

    localparam int DEPTH  = 8;
    localparam int ELEM_W = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flash;
    logic                   stall;
    logic [1:0]             push_number;
    logic [1:0][ELEM_W-1:0] push_data;
    logic                   push_ready;
    logic [1:0][ELEM_W-1:0] issue_require;
    logic [1:0]             iq_size;
    logic [1:0]             iq_pop_number;
    logic [CNT_W-1:0]       count;

    issue_queue_ctrl #(.DEPTH(DEPTH), .ELEM_W(ELEM_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flash         (flash),
        .stall         (stall),
        .push_number   (push_number),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .issue_require (issue_require),
        .iq_size       (iq_size),
        .iq_pop_number (iq_pop_number),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              fl;
        logic              st;
        logic [1:0]        pn;
        logic [ELEM_W-1:0] d0;
        logic [ELEM_W-1:0] d1;
        logic [1:0]        pop;
        int                exp_count;
        int                exp_size;
        logic              exp_ready;
    } vec_t;

    vec_t              vecs[15];
    logic [ELEM_W-1:0] sb[$];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the reference queue
    task automatic check_outputs(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, " count"}, int'(count), sz);
        chk({tag, " iq_size"}, int'(iq_size), (sz > 2) ? 2 : sz);
        chk({tag, " push_ready"}, int'(push_ready), (DEPTH - sz >= 2) ? 1 : 0);
        chk({tag, " issue0"}, int'(issue_require[0]), (sz >= 1) ? int'(sb[0]) : 0);
        chk({tag, " issue1"}, int'(issue_require[1]), (sz >= 2) ? int'(sb[1]) : 0);
    endtask

    // Drive one cycle of stimulus, update the model, check after the edge
    task automatic step(input logic fl, input logic st, input logic [1:0] pn,
                        input logic [ELEM_W-1:0] d0, input logic [ELEM_W-1:0] d1,
                        input logic [1:0] pop, input string tag);
        int p, q, sz;
        logic [ELEM_W-1:0] seen[2];
        logic [ELEM_W-1:0] exp_v;
        flash = fl; stall = st; push_number = pn;
        push_data[0] = d0; push_data[1] = d1; iq_pop_number = pop;
        seen[0] = issue_require[0];
        seen[1] = issue_require[1];
        sz = sb.size();
        if (fl) begin
            sb.delete();
        end else begin
            q = st ? 0 : int'(pop);
            if (q > sz) q = sz;
            if (q > 2) q = 2;
            p = (sz <= DEPTH - 2 && pn != 2'd3) ? int'(pn) : 0;
            for (int i = 0; i < q; i++) begin
                exp_v = sb.pop_front();
                chk({tag, " popped"}, int'(seen[i]), int'(exp_v));
            end
            if (p >= 1) sb.push_back(d0);
            if (p == 2) sb.push_back(d1);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // {flash, stall, push_number, d0, d1, pop, count, iq_size, push_ready}
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 16'h00A0, 16'h00B0, 2'd0, 2, 2, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 16'h00C0, 16'h0000, 2'd0, 3, 2, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 16'h00D0, 16'h00E0, 2'd1, 4, 2, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 16'h00F0, 16'h0100, 2'd0, 6, 2, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 16'h0110, 16'h0000, 2'd0, 7, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 16'hDEAD, 16'hBEEF, 2'd0, 7, 2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 5, 2, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 2'd2, 5, 2, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 3, 2, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 2'd2, 3, 2, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd2, 16'h0AAA, 16'h0BBB, 2'd2, 0, 0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd1, 16'h0120, 16'h0000, 2'd0, 1, 1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 0, 0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'd3, 16'h0EEE, 16'h0FFF, 2'd0, 0, 0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 2'd3, 0, 0, 1'b1};

        rst = 1'b1; flash = 1'b0; stall = 1'b0; push_number = 2'd0;
        push_data = '0; iq_pop_number = 2'd0;
        #1;
        check_outputs("in_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors; first push lands on the first edge after reset release
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].fl, vecs[i].st, vecs[i].pn, vecs[i].d0, vecs[i].d1,
                 vecs[i].pop, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d tbl_size", i), int'(iq_size), vecs[i].exp_size);
            chk($sformatf("vec%0d tbl_ready", i), int'(push_ready), int'(vecs[i].exp_ready));
        end

        // Offset pointers, then fill, drain, refill across the 7->0 wrap
        step(0, 0, 2'd1, 16'h0200, 16'h0000, 2'd0, "offset_push");
        step(0, 0, 2'd0, 16'h0000, 16'h0000, 2'd1, "offset_pop");
        for (int i = 0; i < 4; i++)
            step(0, 0, 2'd2, 16'h1000 + 16'(2*i), 16'h1001 + 16'(2*i), 2'd0, "fill");
        chk("full count", int'(count), DEPTH);
        chk("full ready", int'(push_ready), 0);
        step(0, 0, 2'd1, 16'h0BAD, 16'h0000, 2'd0, "push_when_full");
        for (int i = 0; i < 3; i++)
            step(0, 0, 2'd0, 16'h0000, 16'h0000, 2'd2, "drain6");
        chk("after_drain count", int'(count), 2);
        for (int i = 0; i < 2; i++)
            step(0, 0, 2'd2, 16'h2000 + 16'(2*i), 16'h2001 + 16'(2*i), 2'd0, "refill");
        step(0, 0, 2'd1, 16'h2100, 16'h0000, 2'd1, "push_pop_wrap");
        for (int i = 0; i < 4; i++)
            step(0, 0, 2'd0, 16'h0000, 16'h0000, 2'd2, "drain_wrap");
        chk("drained count", int'(count), 0);

        // Asynchronous reset mid-operation
        step(0, 0, 2'd2, 16'h3000, 16'h3001, 2'd0, "pre_rst");
        step(0, 0, 2'd2, 16'h3002, 16'h3003, 2'd1, "pre_rst2");
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 2'd2, 16'h4000, 16'h4001, 2'd0, "post_rst");
        step(0, 0, 2'd0, 16'h0000, 16'h0000, 2'd2, "post_rst_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
